// File: rtl/game_round_ctrl_pkg.sv
// game_round_ctrl_pkg: shared state encodings, bike constants and helpers for the round sequencer.
package game_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAYING   = 2'd2,
        ST_RESULT    = 2'd3
    } state_t;

    localparam int NUM_BIKES = 4;
    localparam logic [2:0] WIN_DRAW = 3'd0;
    localparam logic [NUM_BIKES-1:0] MASK_2P = 4'b0011;
    localparam logic [NUM_BIKES-1:0] MASK_4P = 4'b1111;

    function automatic logic [2:0] popcount(input logic [NUM_BIKES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_BIKES; i++) n = n + 3'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/game_round_ctrl_round_winner_sel.sv
// round_winner_sel: decides whether the round is over and which bike, if any, survived alone.
module round_winner_sel
    import game_round_ctrl_pkg::*;
(
    input  logic [NUM_BIKES-1:0] nxt,
    input  logic [NUM_BIKES-1:0] mask,
    output logic                 fin,
    output logic [2:0]           winner
);

    logic [NUM_BIKES-1:0] alive;

    assign alive = mask & ~nxt;
    // mask[3] is only set in 4-player mode, so it doubles as the mode flag
    assign fin = mask[3] ? (popcount(nxt) >= 3'd3) : (nxt[0] | nxt[1]);

    always_comb begin
        winner = WIN_DRAW;
        for (int i = 0; i < NUM_BIKES; i++)
            if (alive == NUM_BIKES'(1 << i)) winner = 3'(i + 1);
    end

endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer - start, countdown, play gating, winner decision, scoring, result hold.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int COUNTDOWN_TICKS = 3,
    parameter int RESULT_TICKS    = 120,
    parameter int SCORE_W         = 4,
    parameter int TICK_W          = 8
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           frame_tick,
    input  logic                           start_btn,
    input  logic                           four_player_mode,
    input  logic [NUM_BIKES-1:0]           crash_in,
    output logic [NUM_BIKES-1:0]           bike_enable,
    output logic                           clear_trails,
    output logic                           game_active,
    output logic                           game_finished,
    output logic [2:0]                     winner,
    output logic [TICK_W-1:0]              countdown_val,
    output logic [NUM_BIKES*SCORE_W-1:0]   scores
);

    state_t                         state, state_nxt;
    logic                           start_prev, mode_r, mode_nxt, clr_nxt;
    logic [NUM_BIKES-1:0]           crashed, crashed_nxt, mask, nxt;
    logic [TICK_W-1:0]              cnt, cnt_nxt;
    logic [2:0]                     win_nxt, win_code;
    logic [NUM_BIKES*SCORE_W-1:0]   scores_nxt;
    logic                           rise, fin;

    assign rise = start_btn & ~start_prev;
    assign mask = mode_r ? MASK_4P : MASK_2P;
    assign nxt  = crashed | (crash_in & mask);

    round_winner_sel u_sel (
        .nxt    (nxt),
        .mask   (mask),
        .fin    (fin),
        .winner (win_code)
    );

    assign game_active   = state == ST_PLAYING;
    assign game_finished = state == ST_RESULT;
    assign bike_enable   = game_active ? (mask & ~crashed) : '0;
    // one counter serves both countdown and result hold; only the countdown is shown
    assign countdown_val = (state == ST_COUNTDOWN) ? cnt : '0;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        crashed_nxt = crashed;
        mode_nxt    = mode_r;
        win_nxt     = winner;
        clr_nxt     = 1'b0;
        scores_nxt  = scores;
        case (state)
            ST_IDLE: if (rise) begin
                state_nxt   = ST_COUNTDOWN;
                mode_nxt    = four_player_mode;
                crashed_nxt = '0;
                cnt_nxt     = TICK_W'(COUNTDOWN_TICKS);
                clr_nxt     = 1'b1;
                win_nxt     = WIN_DRAW;
            end
            ST_COUNTDOWN: if (frame_tick) begin
                cnt_nxt = cnt - TICK_W'(1);
                if (cnt == TICK_W'(1)) state_nxt = ST_PLAYING;
            end
            ST_PLAYING: begin
                crashed_nxt = nxt;
                if (fin) begin
                    state_nxt = ST_RESULT;
                    win_nxt   = win_code;
                    cnt_nxt   = TICK_W'(RESULT_TICKS);
                    for (int p = 0; p < NUM_BIKES; p++)
                        if (win_code == 3'(p + 1) && scores[p*SCORE_W +: SCORE_W] != '1)
                            scores_nxt[p*SCORE_W +: SCORE_W] = scores[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
                end
            end
            default: if (frame_tick) begin
                cnt_nxt = cnt - TICK_W'(1);
                if (cnt == TICK_W'(1)) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            start_prev   <= 1'b1;
            mode_r       <= 1'b0;
            crashed      <= '0;
            cnt          <= '0;
            winner       <= WIN_DRAW;
            clear_trails <= 1'b0;
            scores       <= '0;
        end else begin
            state        <= state_nxt;
            start_prev   <= start_btn;
            mode_r       <= mode_nxt;
            crashed      <= crashed_nxt;
            cnt          <= cnt_nxt;
            winner       <= win_nxt;
            clear_trails <= clr_nxt;
            scores       <= scores_nxt;
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed checks of start, countdown, 2/4-player endings, scoring and reset.
module tb_game_round_ctrl;

    logic        clock, resetn, frame_tick, start_btn, four_player_mode;
    logic [3:0]  crash_in, bike_enable;
    logic        clear_trails, game_active, game_finished;
    logic [2:0]  winner;
    logic [7:0]  countdown_val;
    logic [15:0] scores;
    int          total = 0, bad = 0;

    game_round_ctrl dut (
        .clock            (clock),
        .resetn           (resetn),
        .frame_tick       (frame_tick),
        .start_btn        (start_btn),
        .four_player_mode (four_player_mode),
        .crash_in         (crash_in),
        .bike_enable      (bike_enable),
        .clear_trails     (clear_trails),
        .game_active      (game_active),
        .game_finished    (game_finished),
        .winner           (winner),
        .countdown_val    (countdown_val),
        .scores           (scores)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic crash(input logic [3:0] c);
        crash_in = c;
        step();
        crash_in = 4'b0;
    endtask

    task automatic start_round(input logic mode);
        start_btn = 1'b0;
        step();
        four_player_mode = mode;
        start_btn = 1'b1;
        step();
        chk("start_clr", clear_trails, 1);
        chk("start_win_clr", winner, 0);
        chk("start_cd", countdown_val, 3);
        start_btn = 1'b0;
        four_player_mode = ~mode;
        ticks(3);
        chk("start_active", game_active, 1);
    endtask

    initial begin
        logic [3:0] exp_s0;
        resetn = 1'b0;
        frame_tick = 1'b0;
        start_btn = 1'b1;
        four_player_mode = 1'b0;
        crash_in = 4'b0;
        step();
        step();
        chk("rst_be", bike_enable, 0);
        chk("rst_flags", {clear_trails, game_active, game_finished}, 0);
        chk("rst_win", winner, 0);
        chk("rst_scores", scores, 0);
        resetn = 1'b1;
        step();
        step();
        step();
        chk("held_no_clr", clear_trails, 0);
        chk("held_no_cd", countdown_val, 0);

        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        chk("r1_clr", clear_trails, 1);
        chk("r1_cd3", countdown_val, 3);
        start_btn = 1'b0;
        ticks(1);
        chk("r1_clr_once", clear_trails, 0);
        chk("r1_cd2", countdown_val, 2);
        chk("r1_cd_be", bike_enable, 0);
        ticks(2);
        chk("r1_active", game_active, 1);
        chk("r1_cd0", countdown_val, 0);
        chk("r1_be", bike_enable, 4'b0011);
        crash(4'b0010);
        chk("r1_fin", game_finished, 1);
        chk("r1_win", winner, 1);
        chk("r1_scores", scores, 16'h0001);
        chk("r1_be_off", bike_enable, 0);
        ticks(60);
        start_btn = 1'b1;
        ticks(59);
        chk("r1_hold", game_finished, 1);
        ticks(1);
        chk("r1_idle", game_finished, 0);
        chk("r1_win_kept", winner, 1);
        step();
        chk("r1_btn_ignored", clear_trails, 0);
        chk("r1_btn_no_cd", countdown_val, 0);

        start_round(1'b0);
        crash(4'b1100);
        chk("r2_ign_active", game_active, 1);
        chk("r2_ign_be", bike_enable, 4'b0011);
        crash(4'b0011);
        chk("r2_fin", game_finished, 1);
        chk("r2_draw", winner, 0);
        chk("r2_scores", scores, 16'h0001);
        ticks(120);

        start_round(1'b1);
        chk("r3_be4", bike_enable, 4'b1111);
        crash(4'b0001);
        frame_tick = 1'b1;
        crash(4'b1000);
        frame_tick = 1'b0;
        chk("r3_still", game_active, 1);
        chk("r3_be", bike_enable, 4'b0110);
        crash(4'b0100);
        chk("r3_fin", game_finished, 1);
        chk("r3_win", winner, 2);
        chk("r3_scores", scores, 16'h0011);
        ticks(120);
        chk("r3_idle", game_finished | game_active, 0);

        exp_s0 = 4'd1;
        for (int r = 0; r < 16; r++) begin
            start_round(1'b0);
            crash(4'b0010);
            exp_s0 = (exp_s0 == 4'd15) ? 4'd15 : exp_s0 + 4'd1;
            chk("sat_win", winner, 1);
            chk("sat_score", scores, {12'h001, exp_s0});
            ticks(120);
        end
        chk("sat_final", scores[3:0], 15);

        start_round(1'b0);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_active", game_active, 0);
        chk("mid_rst_be", bike_enable, 0);
        chk("mid_rst_scores", scores, 0);
        chk("mid_rst_win", winner, 0);
        chk("mid_rst_cd", countdown_val, 0);
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_idle", {game_active, game_finished, clear_trails}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer that consumes the per-bike crash flags and acts on game end: it starts rounds, runs a pre-round countdown, gates bike movement, decides the winner, keeps scores and holds the result screen.
- Sits between the bike movement/collision logic (upstream, supplies crash_in) and the VGA/score display (downstream).
- Applies the same end rule as the existing end-of-game detector:
  - 2-player mode: the round ends when bike 1 or bike 2 crashes.
  - 4-player mode: the round ends when at least 3 of the 4 bikes have crashed.

Parameters:
- COUNTDOWN_TICKS, 3, number of frame ticks in the pre-round countdown (1..2^TICK_W-1).
- RESULT_TICKS, 120, number of frame ticks the result is held before returning to idle (1..2^TICK_W-1).
- SCORE_W, 4, width of each player's win counter.
- TICK_W, 8, width of the internal tick counter.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  start request, level; edge-detected internally
- four_player_mode  in  1  mode select; sampled only when a round starts
- crash_in  in  4  raw per-bike crash indications, bit0 = bike 1; may be single-cycle pulses
- bike_enable  out  4  movement enable per bike
- clear_trails  out  1  one-cycle pulse that clears the arena
- game_active  out  1  high in PLAYING
- game_finished  out  1  high in RESULT
- winner  out  3  0 = draw/none, 1..4 = winning bike
- countdown_val  out  TICK_W  remaining countdown ticks, for display
- scores  out  4*SCORE_W  player p's score in bits [p*SCORE_W +: SCORE_W], p = 0..3

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state = IDLE
  - all outputs 0
  - scores = 0
  - crashed = 0
  - start edge detector primed to 1, so a button held through reset does not start a round
- States: IDLE, COUNTDOWN, PLAYING, RESULT. Counters and the sticky crash register are all registered.
- IDLE:
  - A rising edge of start_btn (prev = 0, now = 1) moves to COUNTDOWN next cycle.
  - On that transition: latch four_player_mode into mode_r, clear crashed, load countdown_val = COUNTDOWN_TICKS, pulse clear_trails for exactly 1 cycle (the first COUNTDOWN cycle).
- COUNTDOWN:
  - Each frame_tick decrements countdown_val.
  - A frame_tick seen while countdown_val == 1 sets countdown_val to 0 and moves to PLAYING next cycle.
  - bike_enable = 0 throughout.
- PLAYING:
  - game_active = 1.
  - mask = 4'b1111 if mode_r = 1, else 4'b0011.
  - nxt = crashed | (crash_in & mask); crashed <= nxt every cycle.
  - bike_enable = mask & ~crashed.
  - fin = mode_r ? (popcount(nxt) >= 3) : (nxt[0] | nxt[1]).
  - If fin in cycle N:
    - state = RESULT at N+1.
    - winner registered at N+1: the single bit of mask & ~nxt if exactly one is set, else 0 (simultaneous final crashes give a draw).
    - The winner's score increments, saturating at 2^SCORE_W-1. No score change on a draw.
  - crash_in bits outside mask are ignored.
- RESULT:
  - game_finished = 1, bike_enable = 0, winner held.
  - Load tick counter = RESULT_TICKS on entry; decrement on frame_tick; a tick seen at 1 moves to IDLE.
  - start_btn and crash_in are ignored.
  - winner stays valid in IDLE until the next round starts; it clears to 0 on COUNTDOWN entry.
- General rules:
  - crash_in is ignored outside PLAYING.
  - four_player_mode changes mid-round have no effect.
  - A frame_tick and a crash in the same cycle: the crash takes priority; no countdown applies in PLAYING.
  - Reset mid-round returns to IDLE and clears scores.

Decomposition:
- Shared package/header holds:
  - state encodings: ST_IDLE = 0, ST_COUNTDOWN = 1, ST_PLAYING = 2, ST_RESULT = 3
  - player count constant NUM_BIKES = 4
  - winner encoding WIN_DRAW = 0
- One natural sub-module: round_winner_sel. It is combinational: inputs nxt and mask; outputs fin and winner code. It is reused by the scoring display.

Test Plan:
- Reset with start_btn held at 1, then release and press -> no start while held; after the press, clear_trails pulses for exactly 1 cycle and countdown_val = 3.
- 2-player mode, 3 frame_ticks -> PLAYING, bike_enable = 4'b0011. Pulse crash_in = 4'b0010 at cycle N -> at N+1: state RESULT, winner = 1, scores[3:0] = 1, bike_enable = 0.
- 2-player mode, crash_in = 4'b0011 in a single cycle -> winner = 0 (draw), no score change. A crash_in = 4'b1100 pulse earlier in the round is ignored.
- 4-player mode, bikes 1, 3, 4 crash in separate cycles -> RESULT the cycle after the third crash, winner = 2, scores[7:4] = 1. After 2 crashes the state is still PLAYING with bike_enable = 4'b0110 (bikes 1 and 4 crashed).
- 16 consecutive bike-1 wins with SCORE_W = 4 -> score saturates at 15. After 120 frame_ticks in RESULT -> IDLE. start_btn pressed during RESULT -> ignored.
- Assert resetn mid-PLAYING -> immediate IDLE, all outputs 0, scores = 0.
